// File: rtl/reverse_bits_pkg.sv
// Shared types and constants for the reverse_bits streaming pipeline.
package reverse_bits_pkg;

    typedef enum logic [1:0] {
        REV_BIT    = 2'b00,
        REV_NIB    = 2'b01,
        REV_BYTE   = 2'b10,
        REV_BYPASS = 2'b11
    } rev_mode_e;

    localparam int unsigned PIPE_LATENCY = 2;

endpackage

// File: rtl/reverse_bits_core.sv
// Purely combinational WIDTH-bit reverser at bit, nibble, byte or bypass granularity.
module reverse_bits_core
    import reverse_bits_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] rev
);

    localparam int unsigned NUM_NIB  = WIDTH / 4;
    localparam int unsigned NUM_BYTE = WIDTH / 8;

    logic [WIDTH-1:0] rev_bit;
    logic [WIDTH-1:0] rev_nib;
    logic [WIDTH-1:0] rev_byte;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign rev_bit[i] = data[WIDTH-1-i];
    end

    for (genvar k = 0; k < NUM_NIB; k++) begin : g_nib
        assign rev_nib[4*k +: 4] = data[4*(NUM_NIB-1-k) +: 4];
    end

    for (genvar k = 0; k < NUM_BYTE; k++) begin : g_byte
        assign rev_byte[8*k +: 8] = data[8*(NUM_BYTE-1-k) +: 8];
    end

    always_comb begin
        rev = data;
        unique case (rev_mode_e'(mode))
            REV_BIT:    rev = rev_bit;
            REV_NIB:    rev = rev_nib;
            REV_BYTE:   rev = rev_byte;
            REV_BYPASS: rev = data;
            default:    rev = data;
        endcase
    end

endmodule

// File: rtl/reverse_bits_pipe.sv
// Two-stage elastic reverser with palindrome flag; optional saturating palindrome
// counter enabled by defining REVERSE_BITS_PAL_CNT_EN.
module reverse_bits_pipe
    import reverse_bits_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_pal,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] pal_count
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] s1_rev;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] core_rev;
    logic             s1_pal;

    reverse_bits_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .data(in_data),
        .mode(in_mode),
        .rev (core_rev)
    );

    // in_ready looks through S2 to out_ready so a full pipe still streams at 1 word/cycle.
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign out_valid = s2_valid;
    assign s1_pal    = (rev_mode_e'(s1_mode) == REV_BYPASS) || (s1_rev == s1_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_rev   <= '0;
            s1_mode  <= '0;
        end else begin
            s1_valid <= s1_load || (s1_valid && !s2_load);
            if (s1_load) begin
                s1_data <= in_data;
                s1_rev  <= core_rev;
                s1_mode <= in_mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_pal  <= 1'b0;
            out_mode <= '0;
        end else begin
            s2_valid <= s2_load || (s2_valid && !out_ready);
            if (s2_load) begin
                out_data <= s1_rev;
                out_pal  <= s1_pal;
                out_mode <= s1_mode;
            end
        end
    end

`ifdef REVERSE_BITS_PAL_CNT_EN
    logic [CNT_W-1:0] pal_cnt;

    // Counts only delivered results, saturating instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_cnt <= '0;
        end else if (out_valid && out_ready && out_pal && (pal_cnt != {CNT_W{1'b1}})) begin
            pal_cnt <= pal_cnt + CNT_W'(1);
        end
    end

    assign pal_count = pal_cnt;
`else
    assign pal_count = '0;
`endif

endmodule
